// File: rtl/instr_realign_buffer.sv
// +--------------------------------------------------------------------------+
// | instr_realign_buffer: halfword FIFO realigning 16/32-bit instructions    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_realign_buffer #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_valid_i,
  input  logic [31:0]     fetch_data_i,
  output logic            fetch_ready_o,
  input  logic            flush_i,
  input  logic [PC_W-1:0] flush_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_instr_o,
  output logic [PC_W-1:0] out_pc_o,
  output logic            out_compressed_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] READY_MAX = PTR_W'(DEPTH - 2);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_TWO   = PTR_W'(2);
  localparam logic [PC_W-1:0]  PC_ALIGN  = ~PC_W'(1);

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             drop_low_q, drop_low_d;

  logic [PTR_W-1:0] count;
  logic [15:0]      h0, h1;
  logic             head_comp;
  logic             fetch_fire, out_fire;
  logic             wr_lo_en, wr_hi_en;
  logic [AW-1:0]    wr_lo_idx, wr_hi_idx;

  assign count     = wptr_q - rptr_q;
  assign h0        = mem_q[rptr_q[AW-1:0]];
  assign h1        = mem_q[rptr_q[AW-1:0] + AW'(1)];
  assign head_comp = (h0[1:0] != 2'b11);

  // Ready uses the pre-read count so a full buffer never relies on a same-cycle drain.
  assign fetch_ready_o    = (count <= READY_MAX) && !flush_i;
  assign out_valid_o      = !flush_i &&
                            ((count >= PTR_ONE && head_comp) ||
                             (count >= PTR_TWO && !head_comp));
  assign out_instr_o      = head_comp ? {16'h0000, h0} : {h1, h0};
  assign out_pc_o         = pc_q;
  assign out_compressed_o = (count != '0) && head_comp;

  assign fetch_fire = fetch_valid_i && fetch_ready_o;
  assign out_fire   = out_valid_o && out_ready_i;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    pc_d       = pc_q;
    drop_low_d = drop_low_q;
    wr_lo_en   = 1'b0;
    wr_hi_en   = 1'b0;
    wr_lo_idx  = wptr_q[AW-1:0];
    wr_hi_idx  = wptr_q[AW-1:0] + AW'(1);

    if (flush_i) begin
      wptr_d     = rptr_q;
      pc_d       = flush_pc_i & PC_ALIGN;
      drop_low_d = flush_pc_i[1];
    end else begin
      if (fetch_fire) begin
        if (drop_low_q) begin
          // Redirect landed on the upper halfword: skip the lower one once.
          wr_hi_en   = 1'b1;
          wr_hi_idx  = wptr_q[AW-1:0];
          wptr_d     = wptr_q + PTR_ONE;
          drop_low_d = 1'b0;
        end else begin
          wr_lo_en = 1'b1;
          wr_hi_en = 1'b1;
          wptr_d   = wptr_q + PTR_TWO;
        end
      end
      if (out_fire) begin
        rptr_d = rptr_q + (head_comp ? PTR_ONE : PTR_TWO);
        pc_d   = pc_q + (head_comp ? PC_W'(2) : PC_W'(4));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      pc_q       <= '0;
      drop_low_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      pc_q       <= pc_d;
      drop_low_q <= drop_low_d;
    end
  end

  // Data storage is left unreset; emptiness is carried entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_lo_en) mem_q[wr_lo_idx] <= fetch_data_i[15:0];
    if (wr_hi_en) mem_q[wr_hi_idx] <= fetch_data_i[31:16];
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_realign_buffer.sv
// +--------------------------------------------------------------------------+
// | tb_instr_realign_buffer: directed self-checking bench for the realigner  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_instr_realign_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_data_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        out_compressed_o;

  int total = 0;
  int bad   = 0;

  instr_realign_buffer #(.DEPTH(8), .PC_W(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .fetch_valid_i    (fetch_valid_i),
    .fetch_data_i     (fetch_data_i),
    .fetch_ready_o    (fetch_ready_o),
    .flush_i          (flush_i),
    .flush_pc_i       (flush_pc_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_instr_o      (out_instr_o),
    .out_pc_o         (out_pc_o),
    .out_compressed_o (out_compressed_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Compressed-looking halfword (low bits 01) carrying a unique tag.
  function automatic logic [15:0] hw(input int n);
    return {n[13:0], 2'b01};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    int          n;

    rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; out_ready_i = 1'b0;
    fetch_data_i = '0; flush_pc_i = '0;
    @(negedge clk_i);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ready", fetch_ready_o, 1);
    chk("rst_comp", out_compressed_o, 0);
    step();
    rst_i = 1'b0;
    #1 chk("post_rst_valid", out_valid_o, 0);

    // Flush to 0x100 then one 32-bit instruction
    flush_i = 1'b1; flush_pc_i = 32'h100;
    #1 chk("flush_ready", fetch_ready_o, 0);
    chk("flush_valid", out_valid_o, 0);
    step();
    flush_i = 1'b0;
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00130293;
    #1 chk("f1_ready", fetch_ready_o, 1);
    step();
    fetch_valid_i = 1'b0;
    #1 chk("f1_valid", out_valid_o, 1);
    chk("f1_instr", out_instr_o, 32'h00130293);
    chk("f1_pc", out_pc_o, 32'h100);
    chk("f1_comp", out_compressed_o, 0);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    #1 chk("f1_drained", out_valid_o, 0);

    // Two compressed instructions in one word
    fetch_valid_i = 1'b1; fetch_data_i = 32'h40014505;
    step();
    fetch_valid_i = 1'b0;
    #1 chk("c2a_instr", out_instr_o, 32'h00004505);
    chk("c2a_pc", out_pc_o, 32'h104);
    chk("c2a_comp", out_compressed_o, 1);
    out_ready_i = 1'b1;
    step();
    #1 chk("c2b_valid", out_valid_o, 1);
    chk("c2b_instr", out_instr_o, 32'h00004001);
    chk("c2b_pc", out_pc_o, 32'h106);
    chk("c2b_comp", out_compressed_o, 1);
    step();
    #1 chk("c2_empty", out_valid_o, 0);
    out_ready_i = 1'b0;

    // 32-bit instruction split across two fetch words
    fetch_valid_i = 1'b1; fetch_data_i = 32'h02934505;
    step();
    fetch_valid_i = 1'b0;
    #1 chk("sp_c_instr", out_instr_o, 32'h00004505);
    chk("sp_c_pc", out_pc_o, 32'h108);
    out_ready_i = 1'b1;
    step();
    #1 chk("sp_wait_valid", out_valid_o, 0);
    chk("sp_wait_comp", out_compressed_o, 0);
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00000013;
    step();
    fetch_valid_i = 1'b0;
    #1 chk("sp_w_valid", out_valid_o, 1);
    chk("sp_w_instr", out_instr_o, 32'h00130293);
    chk("sp_w_pc", out_pc_o, 32'h10A);
    chk("sp_w_comp", out_compressed_o, 0);
    step();
    #1 chk("sp_z_valid", out_valid_o, 1);
    chk("sp_z_instr", out_instr_o, 32'h00000000);
    chk("sp_z_pc", out_pc_o, 32'h10E);
    chk("sp_z_comp", out_compressed_o, 1);
    step();
    #1 chk("sp_empty", out_valid_o, 0);
    out_ready_i = 1'b0;

    // Flush to halfword-offset target drops the low halfword once
    flush_i = 1'b1; flush_pc_i = 32'h202;
    step();
    flush_i = 1'b0;
    fetch_valid_i = 1'b1; fetch_data_i = 32'h4505ABCD;
    step();
    fetch_valid_i = 1'b0;
    #1 chk("dl_instr", out_instr_o, 32'h00004505);
    chk("dl_pc", out_pc_o, 32'h202);
    chk("dl_comp", out_compressed_o, 1);
    out_ready_i = 1'b1;
    step();
    #1 chk("dl_only_one", out_valid_o, 0);
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00050001;
    step();
    fetch_valid_i = 1'b0;
    #1 chk("dl_clr_lo_instr", out_instr_o, 32'h00000001);
    chk("dl_clr_lo_pc", out_pc_o, 32'h204);
    step();
    #1 chk("dl_clr_hi_instr", out_instr_o, 32'h00000005);
    chk("dl_clr_hi_pc", out_pc_o, 32'h206);
    step();
    #1 chk("dl_clr_empty", out_valid_o, 0);
    out_ready_i = 1'b0;

    // Fill to capacity with the consumer stalled, then drain; repeated to wrap pointers
    flush_i = 1'b1; flush_pc_i = 32'h1000;
    step();
    flush_i = 1'b0;
    exp_pc = 32'h1000;
    n = 0;
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 4; w++) begin
        fetch_valid_i = 1'b1;
        fetch_data_i  = {hw(n + 2*w + 1), hw(n + 2*w)};
        #1 chk("fill_ready", fetch_ready_o, 1);
        step();
      end
      fetch_data_i = 32'hFFFFFFFF;
      #1 chk("full_ready", fetch_ready_o, 0);
      step();
      fetch_valid_i = 1'b0;
      #1 chk("full_hold_ready", fetch_ready_o, 0);
      out_ready_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
        #1 chk("drain_valid", out_valid_o, 1);
        chk("drain_instr", out_instr_o, {16'h0000, hw(n + k)});
        chk("drain_pc", out_pc_o, exp_pc);
        chk("drain_ready", fetch_ready_o, logic'((8 - k) <= 6));
        step();
        exp_pc = exp_pc + 32'd2;
      end
      out_ready_i = 1'b0;
      n = n + 8;
      #1 chk("drain_empty", out_valid_o, 0);
    end

    // Flush with both handshakes pending
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00050001;
    step();
    fetch_valid_i = 1'b0;
    #1 chk("pre_fl_valid", out_valid_o, 1);
    chk("pre_fl_pc", out_pc_o, exp_pc);
    flush_i = 1'b1; flush_pc_i = 32'h300;
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00090009;
    out_ready_i = 1'b1;
    #1 chk("fl_valid", out_valid_o, 0);
    chk("fl_ready", fetch_ready_o, 0);
    step();
    flush_i = 1'b0; fetch_valid_i = 1'b0; out_ready_i = 1'b0;
    #1 chk("post_fl_valid", out_valid_o, 0);
    chk("post_fl_ready", fetch_ready_o, 1);
    chk("post_fl_comp", out_compressed_o, 0);
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00050001;
    step();
    fetch_valid_i = 1'b0;
    #1 chk("post_fl_pc", out_pc_o, 32'h300);
    chk("post_fl_instr", out_instr_o, 32'h00000001);

    // Asynchronous reset with data buffered
    rst_i = 1'b1;
    #1 chk("arst_valid", out_valid_o, 0);
    chk("arst_ready", fetch_ready_o, 1);
    chk("arst_comp", out_compressed_o, 0);
    chk("arst_pc", out_pc_o, 32'h0);
    step();
    rst_i = 1'b0;
    #1 chk("arst_after_valid", out_valid_o, 0);
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00050001;
    step();
    fetch_valid_i = 1'b0;
    #1 chk("arst_new_valid", out_valid_o, 1);
    chk("arst_new_pc", out_pc_o, 32'h0);
    chk("arst_new_instr", out_instr_o, 32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_realign_buffer.md
INSTR_REALIGN_BUFFER -- requirements
Module: instr_realign_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning halfword entries in the buffer (power of two, >= 4).
REQ-002 The block SHALL have parameter PC_W, default 32, meaning program-counter width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port fetch_valid_i, input, 1, meaning a fetch word is offered.
REQ-006 The block SHALL have port fetch_data_i, input, 32, meaning the word-aligned fetch word (low halfword = lower address).
REQ-007 The block SHALL have port fetch_ready_o, output, 1, meaning the block can accept a word.
REQ-008 The block SHALL have port flush_i, input, 1, meaning redirect (branch/trap).
REQ-009 The block SHALL have port flush_pc_i, input, PC_W, meaning redirect target.
REQ-010 The block SHALL have port out_valid_o, output, 1, meaning a complete instruction is presented.
REQ-011 The block SHALL have port out_ready_i, input, 1, meaning the decode stage consumes the instruction.
REQ-012 The block SHALL have port out_instr_o, output, 32, meaning the raw instruction, compressed ones zero-extended.
REQ-013 The block SHALL have port out_pc_o, output, PC_W, meaning the address of out_instr_o.
REQ-014 The block SHALL have port out_compressed_o, output, 1, meaning the head instruction is 16-bit.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH 16-bit entries with read/write pointers of log2(DEPTH)+1 bits; count = wptr - rptr, modulo wrap.
REQ-016 fetch_ready_o SHALL be 1 iff count <= DEPTH-2 and flush_i = 0; it is computed on pre-read count (no same-cycle read credit).
REQ-017 A fetch handshake SHALL write low halfword then high halfword (wptr += 2), unless drop_low is set, in which case only the high halfword is written (wptr += 1) and drop_low clears.
REQ-018 Head halfword h0 SHALL be compressed iff h0[1:0] != 2'b11.
REQ-019 out_valid_o SHALL be 1 iff flush_i = 0 and (count >= 1 with h0 compressed, or count >= 2 with h0 uncompressed); a 32-bit instruction split across two fetch words SHALL wait for the second.
REQ-020 out_instr_o SHALL be {16'h0, h0} when compressed, else {h1, h0}; out_compressed_o SHALL follow REQ-018 whenever count >= 1.
REQ-021 On output handshake rptr SHALL advance by 1 (compressed) or 2, and the internal pc by 2 or 4, wrapping modulo 2^PC_W.
REQ-022 Simultaneous fetch and output handshakes in one cycle SHALL both take effect.
REQ-023 Latency SHALL be one cycle: a word accepted in cycle N can produce out_valid_o in cycle N+1.
REQ-024 On flush_i SHALL: wptr = rptr (empty), pc = {flush_pc_i[PC_W-1:1], 1'b0}, drop_low = flush_pc_i[1]; any fetch or output presented that cycle is discarded; flush overrides all other events.
REQ-025 A flush with flush_pc_i[1] = 0 SHALL clear drop_low; consecutive flushes SHALL take the last target.
REQ-026 Outputs SHALL not be registered beyond the buffer; out_* are combinational from buffer state and flush_i.

Reset
REQ-027 While rst_i is high, pointers SHALL be 0, pc SHALL be 0, drop_low SHALL be 0, so out_valid_o = 0 and fetch_ready_o = 1 (if flush_i = 0).
REQ-028 Reset asserted mid-operation SHALL discard all buffered halfwords immediately, without waiting for a clock edge.
REQ-029 Buffer data contents SHALL not require reset.

Verification
REQ-030 Reset, flush to 0x100, fetch 0x00130293 -> out_instr 0x00130293, pc 0x100, compressed 0, one cycle after acceptance.
REQ-031 Fetch 0x40014505 -> two outputs: 0x00004505 at pc P, 0x00004001 at P+2, both compressed 1.
REQ-032 Fetch 0x02934505 then 0x00000013 -> 0x00004505 at P, then 0x00130293 at P+2 only after second word accepted; the 16-bit halfword 0x0000 remains at head (compressed).
REQ-033 Flush to 0x202 then fetch 0x4505ABCD -> only 0x00004505 at pc 0x202; low halfword dropped.
REQ-034 Hold out_ready_i = 0, stream words -> fetch_ready_o drops when count = DEPTH-1 or DEPTH; no overwrite; pointer wrap verified over > 2*DEPTH halfwords.
REQ-035 Assert flush_i with fetch and output handshakes pending, and separately pulse rst_i mid-stream -> buffer empty next cycle, out_valid_o = 0, no stale instruction emitted.
